// File: rtl/ulm_io_unit.sv
// ----------------------------------------------------------------------------
// ulm_io_unit
//   Execution unit for the ULM I/O instructions PUTC (immediate or register
//   operand) and GETC (into a register). Characters sent by PUTC go through a
//   TX FIFO to the serial sink. Characters from the serial source go through an
//   RX FIFO to GETC. The control unit is stalled through op_ready, so no
//   character is ever dropped.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   op_valid/op          decoded I/O op: 00 NOP, 01 PUTC_IMM, 10 PUTC_REG, 11 GETC
//   char_imm             immediate char for PUTC_IMM
//   char_reg             source reg (PUTC_REG) / destination reg (GETC)
//   reg_rdata            register file read data for char_reg, same cycle
//   op_ready             op accepted when op_valid & op_ready
//   wb_en/wb_addr/wb_data   one-cycle register write-back for GETC
//   tx_valid/tx_data/tx_ready   TX FIFO head (first-word fall-through)
//   rx_valid/rx_data/rx_ready   incoming char stream
//   tx_level/rx_level    FIFO occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module ulm_io_unit #(
   parameter int DATA_W    = 8,
   parameter int REG_ADDRW = 4,
   parameter int TX_DEPTH  = 4,
   parameter int RX_DEPTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        op_valid,
   input  logic [1:0]                  op,
   input  logic [DATA_W-1:0]           char_imm,
   input  logic [REG_ADDRW-1:0]        char_reg,
   input  logic [DATA_W-1:0]           reg_rdata,
   output logic                        op_ready,
   output logic                        wb_en,
   output logic [REG_ADDRW-1:0]        wb_addr,
   output logic [DATA_W-1:0]           wb_data,
   output logic                        tx_valid,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_ready,
   input  logic                        rx_valid,
   input  logic [DATA_W-1:0]           rx_data,
   output logic                        rx_ready,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic [$clog2(RX_DEPTH):0]   rx_level
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_LW = TX_AW + 1;
   localparam int RX_LW = RX_AW + 1;

   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_PUTC_IMM = 2'b01;
   localparam logic [1:0] OP_PUTC_REG = 2'b10;
   localparam logic [1:0] OP_GETC     = 2'b11;

   logic [DATA_W-1:0] tx_mem_r [TX_DEPTH];
   logic [TX_AW-1:0]  tx_wptr_r;
   logic [TX_AW-1:0]  tx_rptr_r;
   logic [TX_LW-1:0]  tx_level_r;
   logic [DATA_W-1:0] rx_mem_r [RX_DEPTH];
   logic [RX_AW-1:0]  rx_wptr_r;
   logic [RX_AW-1:0]  rx_rptr_r;
   logic [RX_LW-1:0]  rx_level_r;
   logic              wb_en_r;
   logic [REG_ADDRW-1:0] wb_addr_r;
   logic [DATA_W-1:0] wb_data_r;

   logic              tx_full_s;
   logic              rx_empty_s;
   logic              op_ready_s;
   logic              tx_push_s;
   logic              tx_pop_s;
   logic              rx_push_s;
   logic              rx_pop_s;
   logic [DATA_W-1:0] tx_push_data_s;

   assign tx_full_s  = (tx_level_r == TX_LW'(TX_DEPTH));
   assign rx_empty_s = (rx_level_r == RX_LW'(0));

   // Op acceptance depends only on FIFO state and op, never on tx_ready/rx_valid.
   always_comb begin
      op_ready_s = 1'b1;
      case (op)
         OP_NOP:      op_ready_s = 1'b1;
         OP_PUTC_IMM: op_ready_s = !tx_full_s;
         OP_PUTC_REG: op_ready_s = !tx_full_s;
         OP_GETC:     op_ready_s = !rx_empty_s;
         default:     op_ready_s = 1'b1;
      endcase
   end

   // Decode the push/pop strobes for both FIFOs.
   always_comb begin
      tx_push_s      = 1'b0;
      rx_pop_s       = 1'b0;
      tx_push_data_s = char_imm;
      if (op_valid && op_ready_s) begin
         tx_push_s = (op == OP_PUTC_IMM) || (op == OP_PUTC_REG);
         rx_pop_s  = (op == OP_GETC);
      end else begin
         tx_push_s = 1'b0;
         rx_pop_s  = 1'b0;
      end
      if (op == OP_PUTC_REG) begin
         tx_push_data_s = reg_rdata;
      end else begin
         tx_push_data_s = char_imm;
      end
   end

   assign tx_pop_s  = tx_valid && tx_ready;
   assign rx_push_s = rx_valid && rx_ready;

   // TX circular buffer: storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TX_DEPTH; i++) tx_mem_r[i] <= '0;
         tx_wptr_r  <= '0;
         tx_rptr_r  <= '0;
         tx_level_r <= '0;
      end else begin
         if (tx_push_s) begin
            tx_mem_r[tx_wptr_r] <= tx_push_data_s;
            tx_wptr_r           <= tx_wptr_r + TX_AW'(1);
         end
         if (tx_pop_s) begin
            tx_rptr_r <= tx_rptr_r + TX_AW'(1);
         end
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_level_r <= tx_level_r + TX_LW'(1);
            2'b01:   tx_level_r <= tx_level_r - TX_LW'(1);
            default: tx_level_r <= tx_level_r;
         endcase
      end
   end

   // RX circular buffer: storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RX_DEPTH; i++) rx_mem_r[i] <= '0;
         rx_wptr_r  <= '0;
         rx_rptr_r  <= '0;
         rx_level_r <= '0;
      end else begin
         if (rx_push_s) begin
            rx_mem_r[rx_wptr_r] <= rx_data;
            rx_wptr_r           <= rx_wptr_r + RX_AW'(1);
         end
         if (rx_pop_s) begin
            rx_rptr_r <= rx_rptr_r + RX_AW'(1);
         end
         case ({rx_push_s, rx_pop_s})
            2'b10:   rx_level_r <= rx_level_r + RX_LW'(1);
            2'b01:   rx_level_r <= rx_level_r - RX_LW'(1);
            default: rx_level_r <= rx_level_r;
         endcase
      end
   end

   // GETC write-back: pulse one cycle after accept; address/data hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en_r   <= 1'b0;
         wb_addr_r <= '0;
         wb_data_r <= '0;
      end else begin
         wb_en_r <= rx_pop_s;
         if (rx_pop_s) begin
            wb_addr_r <= char_reg;
            wb_data_r <= rx_mem_r[rx_rptr_r];
         end
      end
   end

   assign op_ready = op_ready_s;
   assign wb_en    = wb_en_r;
   assign wb_addr  = wb_addr_r;
   assign wb_data  = wb_data_r;
   assign tx_valid = (tx_level_r != TX_LW'(0));
   assign tx_data  = tx_mem_r[tx_rptr_r];
   assign rx_ready = (rx_level_r < RX_LW'(RX_DEPTH));
   assign tx_level = tx_level_r;
   assign rx_level = rx_level_r;

endmodule
